// File: rtl/monitor_pkg.sv
// Constants shared between the NV-memory write monitor and the reset sequencer.
// Holds the sequencer state encoding and the monitored-window definitions.
package monitor_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    LOCKED = 2'd2
  } seq_state_e;

  localparam logic [15:0] NVMEM_START       = 16'hF800;
  localparam logic [15:0] NVMEM_SIZE        = 16'h0800;
  localparam int          NVMEM_WIN_CYCLES  = 1024;
  localparam int          NVMEM_WIN_WRITES  = 64;

endpackage

// File: rtl/rise_detect.sv
// Registered rising-edge detector: sig_rise is high the cycle sig is high while its registered copy is low.
// Zero added latency on the rise term; no backpressure, sync reset clears the history to 0.
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic sig,
  output logic sig_rise
);

  logic sig_q;
  logic sig_d;

  always_comb begin
    sig_d = sig;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sig_q <= 1'b0;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig_rise = sig & ~sig_q;

endmodule

// File: rtl/reset_sequencer.sv
// Turns each new write-flood violation into a HOLD_CYCLES cpu_reset pulse, counting decaying strikes up to a sticky lockout.
// Outputs registered, visible one edge after the violation rise; no backpressure, rises during HOLD/LOCKED are dropped.
module reset_sequencer
  import monitor_pkg::*;
#(
  parameter int HOLD_CYCLES  = 16,
  parameter int STRIKE_LIMIT = 3,
  parameter int DECAY_CYCLES = 4096
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              violation,
  output logic                              cpu_reset,
  output logic                              lockout,
  output logic [$clog2(STRIKE_LIMIT+1)-1:0] strikes,
  output logic                              violation_evt
);

  localparam int SW = $clog2(STRIKE_LIMIT + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int DW = $clog2(DECAY_CYCLES + 1);

  localparam logic [SW-1:0] LIMIT      = SW'(STRIKE_LIMIT);
  localparam logic [HW-1:0] HOLD_LOAD  = HW'(HOLD_CYCLES - 1);
  localparam logic [DW-1:0] DECAY_LAST = DW'(DECAY_CYCLES - 1);

  logic          rise;
  seq_state_e    state_q, state_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic [DW-1:0] decay_cnt_q, decay_cnt_d;
  logic [SW-1:0] strikes_q, strikes_d;
  logic          cpu_reset_q, cpu_reset_d;
  logic          lockout_q, lockout_d;
  logic          evt_q, evt_d;

  rise_detect u_rise_detect (
    .clk      (clk),
    .reset    (reset),
    .sig      (violation),
    .sig_rise (rise)
  );

  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    decay_cnt_d = '0;
    strikes_d   = strikes_q;
    evt_d       = 1'b0;

    case (state_q)
      IDLE: begin
        // A rise on the expiry cycle wins: the strike is added and the decay timer restarts.
        if (rise) begin
          evt_d     = 1'b1;
          strikes_d = (strikes_q >= LIMIT) ? LIMIT : strikes_q + 1'b1;
          if (strikes_d == LIMIT) begin
            state_d = LOCKED;
          end else begin
            state_d    = HOLD;
            hold_cnt_d = HOLD_LOAD;
          end
        end else if (strikes_q != '0) begin
          if (decay_cnt_q == DECAY_LAST) begin
            strikes_d = strikes_q - 1'b1;
          end else begin
            decay_cnt_d = decay_cnt_q + 1'b1;
          end
        end
      end
      HOLD: begin
        if (hold_cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          hold_cnt_d = hold_cnt_q - 1'b1;
        end
      end
      LOCKED: begin
        state_d = LOCKED;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    cpu_reset_d = (state_d != IDLE);
    lockout_d   = (state_d == LOCKED);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      hold_cnt_q  <= '0;
      decay_cnt_q <= '0;
      strikes_q   <= '0;
      cpu_reset_q <= 1'b0;
      lockout_q   <= 1'b0;
      evt_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      decay_cnt_q <= decay_cnt_d;
      strikes_q   <= strikes_d;
      cpu_reset_q <= cpu_reset_d;
      lockout_q   <= lockout_d;
      evt_q       <= evt_d;
    end
  end

  assign cpu_reset     = cpu_reset_q;
  assign lockout       = lockout_q;
  assign strikes       = strikes_q;
  assign violation_evt = evt_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: timestamp-based reference model compared every cycle,
// plus directed scenarios with hand-computed expectations and a randomized phase.
module tb_reset_sequencer;

  localparam int HOLD  = 16;
  localparam int LIMIT = 3;
  localparam int DECAY = 4096;
  localparam int SW    = $clog2(LIMIT + 1);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          violation = 1'b0;
  logic          cpu_reset;
  logic          lockout;
  logic [SW-1:0] strikes;
  logic          violation_evt;

  always #5 clk = ~clk;

  reset_sequencer #(
    .HOLD_CYCLES  (HOLD),
    .STRIKE_LIMIT (LIMIT),
    .DECAY_CYCLES (DECAY)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .violation     (violation),
    .cpu_reset     (cpu_reset),
    .lockout       (lockout),
    .strikes       (strikes),
    .violation_evt (violation_evt)
  );

  int     n_checks = 0;
  int     n_fail   = 0;
  longint cyc      = 0;
  bit     cmp_en   = 1'b0;
  int     evt_cnt  = 0;
  int     cpu_cnt  = 0;

  // Reference model: timestamps instead of counters.
  bit     m_cpu, m_lock, m_evt, m_prev_v;
  int     m_strikes;
  longint m_hold_end, m_anchor;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  always @(posedge clk) begin
    bit rise, idle;
    cyc++;
    if (reset) begin
      m_cpu = 0; m_lock = 0; m_evt = 0; m_prev_v = 0;
      m_strikes = 0; m_hold_end = 0; m_anchor = cyc;
    end else begin
      rise  = violation && !m_prev_v;
      idle  = !m_cpu;
      m_evt = 0;
      if (idle) begin
        if (rise) begin
          if (m_strikes < LIMIT) m_strikes++;
          m_evt = 1;
          if (m_strikes == LIMIT) m_lock = 1;
          else m_hold_end = cyc + HOLD;
        end else if (m_strikes > 0 && (cyc - m_anchor) == DECAY) begin
          m_strikes--;
          m_anchor = cyc;
        end
      end
      m_cpu = m_lock || (cyc < m_hold_end);
      if (!idle && !m_cpu) m_anchor = cyc;
      m_prev_v = violation;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cpu_reset", cpu_reset, m_cpu);
      check("lockout", lockout, m_lock);
      check("strikes", strikes, m_strikes);
      check("violation_evt", violation_evt, m_evt);
    end
    if (violation_evt === 1'b1) evt_cnt++;
    if (cpu_reset === 1'b1) cpu_cnt++;
  end

  task automatic do_reset();
    reset = 1'b1;
    violation = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    evt_cnt = 0;
    cpu_cnt = 0;
  endtask

  task automatic pulse();
    violation = 1'b1;
    @(negedge clk);
    violation = 1'b0;
  endtask

  task automatic wait_cpu_low(input int budget);
    int k = 0;
    while (cpu_reset === 1'b1 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("cpu_reset_release_timeout", cpu_reset, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cpu_reset"}, cpu_reset, 0);
    check({tag, "_lockout"}, lockout, 0);
    check({tag, "_strikes"}, strikes, 0);
    check({tag, "_evt"}, violation_evt, 0);
  endtask

  initial begin
    longint t0;
    int k;

    reset = 1'b1;
    repeat (2) @(negedge clk);
    cmp_en = 1'b1;
    check_all_zero("reset_state");
    reset = 1'b0;
    evt_cnt = 0;
    cpu_cnt = 0;

    // Single one-cycle pulse.
    pulse();
    check("pulse_cpu_first", cpu_reset, 1);
    repeat (30) @(negedge clk);
    check("pulse_cpu_len", cpu_cnt, HOLD);
    check("pulse_evt_cnt", evt_cnt, 1);
    check("pulse_strikes", strikes, 1);

    // Long level: one strike only.
    do_reset();
    violation = 1'b1;
    repeat (100) @(negedge clk);
    violation = 1'b0;
    repeat (20) @(negedge clk);
    check("level_cpu_len", cpu_cnt, HOLD);
    check("level_evt_cnt", evt_cnt, 1);
    check("level_strikes", strikes, 1);

    // Three isolated pulses reach lockout; a fourth changes nothing.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      pulse();
      check("lock_step_strikes", strikes, i + 1);
      repeat (49) @(negedge clk);
    end
    check("lock_lockout", lockout, 1);
    check("lock_cpu", cpu_reset, 1);
    check("lock_evt_cnt", evt_cnt, 3);
    pulse();
    repeat (20) @(negedge clk);
    check("lock_4th_strikes", strikes, LIMIT);
    check("lock_4th_evt_cnt", evt_cnt, 3);
    check("lock_4th_cpu", cpu_reset, 1);

    // Reset while LOCKED with violation held high through release.
    violation = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    check_all_zero("rst_locked");
    reset = 1'b0;
    @(negedge clk);
    check("rst_locked_rel_strikes", strikes, 1);
    check("rst_locked_rel_cpu", cpu_reset, 1);
    check("rst_locked_rel_evt", violation_evt, 1);
    violation = 1'b0;

    // Reset mid-HOLD.
    do_reset();
    pulse();
    repeat (5) @(negedge clk);
    violation = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    check_all_zero("rst_hold");
    reset = 1'b0;
    @(negedge clk);
    check("rst_hold_rel_strikes", strikes, 1);
    check("rst_hold_rel_cpu", cpu_reset, 1);
    violation = 1'b0;

    // A rise on the 5th HOLD cycle is ignored.
    do_reset();
    pulse();
    repeat (3) @(negedge clk);
    pulse();
    repeat (30) @(negedge clk);
    check("hold_ign_strikes", strikes, 1);
    check("hold_ign_evt_cnt", evt_cnt, 1);
    check("hold_ign_cpu_len", cpu_cnt, HOLD);

    // Decay: one strike removed exactly DECAY cycles after HOLD exits.
    do_reset();
    pulse();
    wait_cpu_low(40);
    t0 = cyc;
    k = 0;
    while (strikes !== '0 && k < DECAY + 200) begin
      @(negedge clk);
      k++;
    end
    check("decay_gap", cyc - t0, DECAY);

    // Rise landing on the expiry cycle wins over decay.
    do_reset();
    pulse();
    wait_cpu_low(40);
    repeat (DECAY - 1) @(negedge clk);
    pulse();
    check("collide_strikes", strikes, 2);
    check("collide_evt", violation_evt, 1);
    repeat (30) @(negedge clk);
    check("collide_strikes_later", strikes, 2);

    // Randomized phase, checked by the model only.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 7) == 0) violation = ~violation;
      reset = ($urandom_range(0, 799) == 0);
      @(negedge clk);
    end
    reset = 1'b0;
    violation = 1'b0;
    repeat (5) @(negedge clk);
    cmp_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
